// File: rtl/rf_dump_pkg.sv
// Shared types and constants for the register-file dump streamer.
// Frame layout: header byte, then every register little-endian, then an 8-bit checksum.
package rf_dump_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        CSUM = 2'd3
    } state_t;

    localparam logic [7:0] HDR_BYTE      = 8'hA5;
    localparam int         XLEN_DEFAULT  = 32;
    localparam int         NREGS_DEFAULT = 16;
    localparam int         BYTES_PER_REG = XLEN_DEFAULT / 8;
    localparam int         FRAME_BYTES   = 2 + NREGS_DEFAULT * BYTES_PER_REG;

endpackage

// File: rtl/rf_dump_streamer.sv
// Snapshots the architectural register file on start and streams it as a framed,
// checksummed byte sequence over a valid/ready interface.
module rf_dump_streamer
    import rf_dump_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [XLEN-1:0] regs_in [0:NREGS-1],
    output logic            busy,
    output logic            done,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_data,
    output logic            out_last
);

    // Handshake: a byte moves on any cycle with out_valid && out_ready. While
    // out_valid is high without out_ready, out_data/out_last are frozen, and
    // out_valid only falls after a transfer (or on reset).

    localparam int BPR    = XLEN / 8;
    localparam int RIDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int BIDX_W = (BPR > 1) ? $clog2(BPR) : 1;

    state_t              state;
    logic [RIDX_W-1:0]   reg_idx;
    logic [BIDX_W-1:0]   byte_idx;
    logic [RIDX_W-1:0]   nxt_ridx;
    logic [BIDX_W-1:0]   nxt_bidx;
    logic [7:0]          csum;
    logic [7:0]          sum_next;
    logic [7:0]          nxt_byte;
    logic                xfer;
    logic                last_data;
    logic                take;
    logic [XLEN-1:0]     snap [0:NREGS-1];

    assign xfer      = out_valid && out_ready;
    assign take      = (state == IDLE) && start;
    assign sum_next  = csum + out_data;
    assign last_data = (reg_idx == RIDX_W'(NREGS - 1)) && (byte_idx == BIDX_W'(BPR - 1));

    // Indices of the byte that follows the one currently presented; in HDR both are zero.
    always_comb begin
        nxt_ridx = reg_idx;
        nxt_bidx = byte_idx;
        if (state == DATA) begin
            if (byte_idx == BIDX_W'(BPR - 1)) begin
                nxt_bidx = '0;
                nxt_ridx = reg_idx + 1'b1;
            end else begin
                nxt_bidx = byte_idx + 1'b1;
            end
        end
    end

    always_comb begin
        logic [XLEN-1:0] word;
        word     = snap[nxt_ridx];
        nxt_byte = word[{nxt_bidx, 3'b000} +: 8];
    end

    // Snapshot buffer; x0 is architecturally zero whatever the register file shows.
    always_ff @(posedge clk) begin
        if (take) begin
            for (int i = 0; i < NREGS; i++) begin
                snap[i] <= (i == 0) ? '0 : regs_in[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            reg_idx   <= '0;
            byte_idx  <= '0;
            csum      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= HDR;
                        reg_idx   <= '0;
                        byte_idx  <= '0;
                        csum      <= '0;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        out_data  <= HDR_BYTE;
                        out_last  <= 1'b0;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        state    <= DATA;
                        out_data <= nxt_byte;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        csum <= sum_next;
                        if (last_data) begin
                            state    <= CSUM;
                            out_data <= sum_next;
                            out_last <= 1'b1;
                        end else begin
                            reg_idx  <= nxt_ridx;
                            byte_idx <= nxt_bidx;
                            out_data <= nxt_byte;
                        end
                    end
                end
                CSUM: begin
                    if (xfer) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
